regfile_write_arbiter: RTL

- Shares the single register-file write port among NREQ requesters using round-robin arbitration.
- Per cycle it grants at most one requester. It registers the winner's address and data, and drives the write port.
- The register file's address decoder tree (5-to-32 built from smaller decoders) consumes wr_en as its enable and wr_addr as its select.
- Writes to the zero register (X31) are granted but suppressed at the port.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/regfile_write_arbiter_rr_priority_select.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;
    localparam int NREQ_DEF   = 4;

    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd31;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_select.sv
// Round-robin priority search starting at ptr; one-hot grant plus index.
module rr_priority_select
    import regfile_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NREQ is a power of two, so the index wraps by plain truncation.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; one-cycle
// registered write stage, writes to the zero register suppressed.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(NREQ)-1:0]  ptr
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [NREQ-1:0]   sel_grant;
    logic [PTR_W-1:0]  winner;
    logic              grant_any;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rr_priority_select #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_sel (
        .req    (req),
        .ptr    (ptr_q),
        .grant  (sel_grant),
        .winner (winner)
    );

    assign grant     = (stall || reset) ? '0 : sel_grant;
    assign grant_any = |grant;
    assign win_addr  = req_addr[winner*ADDR_W +: ADDR_W];
    assign win_data  = req_data[winner*DATA_W +: DATA_W];

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_any) begin
            ptr_d     = winner + PTR_W'(1);
            wr_en_d   = (win_addr != ADDR_W'(ZERO_REG));
            wr_addr_d = win_addr;
            wr_data_d = win_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ptr     = ptr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
